// File: rtl/status_reg_pkg.sv
// Shared definitions for the status register with interrupt.
//   rd_state_e : read handshake FSM states
//   MAX_WIDTH  : widest supported status vector
//   sticky_vec : MODE_MASK limited to the instantiated width
package status_reg_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2,
    HOLD    = 2'd3
  } rd_state_e;

  // Bits at or above width are forced to 0, so an oversized MODE_MASK is harmless.
  function automatic logic [MAX_WIDTH-1:0] sticky_vec(input logic [MAX_WIDTH-1:0] mode_mask,
                                                      input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) v[i] = mode_mask[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/status_reg_bit.sv
// One status bit: transparent or sticky (latch-high, clear-on-read).
// Set always wins over clear.
// Optional macro STATUS_REG_IRQ_EDGE_EN: sticky bits set on the rising edge of
// status, and irq_src becomes a one-cycle pulse on each sticky set.
// Ports:
//   clock, reset_n : clock / async active-low reset
//   status         : raw status net
//   clr            : clear request (capture cycle); ignored by transparent bits
//   stat_q         : sampled / held status
//   irq_src        : contribution of this bit to the interrupt
module status_reg_bit #(
  parameter bit STICKY = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic status,
  input  logic clr,
  output logic stat_q,
  output logic irq_src
);

  logic set;

`ifdef STATUS_REG_IRQ_EDGE_EN
  logic status_d;
  logic set_q;

  assign set = status & ~status_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      status_d <= 1'b0;
      set_q    <= 1'b0;
    end else begin
      status_d <= status;
      set_q    <= STICKY & set;
    end
  end

  // Aligned with stat_q so irq keeps the same 2-cycle latency as level mode.
  assign irq_src = set_q;
`else
  assign set     = status;
  assign irq_src = stat_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= 1'b0;
    end else if (STICKY) begin
      stat_q <= set | (stat_q & ~clr);
    end else begin
      stat_q <= status;
    end
  end

endmodule

// File: rtl/status_reg_irq.sv
// Parametrised status register with maskable interrupt and req/ack read.
// Optional macro STATUS_REG_IRQ_EDGE_EN: edge-set sticky bits, pulsed irq.
// Ports:
//   clock, reset_n       : clock / async active-low reset
//   status[WIDTH]        : status nets, synchronous to clock
//   rd_req / rd_ack      : level request / one-cycle ack pulse
//   rd_data[WIDTH]       : value captured by the last read
//   mask_wr, mask_data   : interrupt mask write strobe and value
//   int_mask[WIDTH]      : current interrupt mask
//   irq                  : registered OR of masked status
//
// Read FSM:
//   state   | meaning
//   IDLE    | waiting for rd_req
//   CAPTURE | rd_data <= stat_q, sticky bits cleared
//   ACK     | rd_ack high for this cycle
//   HOLD    | waiting for rd_req to drop; no re-capture
module status_reg_irq
  import status_reg_pkg::*;
#(
  parameter int                   WIDTH         = 8,
  parameter logic [MAX_WIDTH-1:0] MODE_MASK     = '0,
  parameter logic [MAX_WIDTH-1:0] INT_MASK_INIT = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] status,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  input  logic             mask_wr,
  input  logic [WIDTH-1:0] mask_data,
  output logic [WIDTH-1:0] int_mask,
  output logic             irq
);

  localparam logic [MAX_WIDTH-1:0] STICKY_ALL = sticky_vec(MODE_MASK, WIDTH);
  localparam logic [WIDTH-1:0]     STICKY     = STICKY_ALL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     MASK_RST   = INT_MASK_INIT[WIDTH-1:0];

  rd_state_e        state;
  logic             capture;
  logic [WIDTH-1:0] stat_q;
  logic [WIDTH-1:0] irq_src;

  assign capture = (state == CAPTURE);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    status_reg_bit #(
      .STICKY(STICKY[i])
    ) u_bit (
      .clock   (clock),
      .reset_n (reset_n),
      .status  (status[i]),
      .clr     (capture),
      .stat_q  (stat_q[i]),
      .irq_src (irq_src[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) state <= CAPTURE;
        end
        CAPTURE: begin
          rd_data <= stat_q;
          rd_ack  <= 1'b1;
          state   <= ACK;
        end
        ACK: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!rd_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      int_mask <= MASK_RST;
      irq      <= 1'b0;
    end else begin
      if (mask_wr) int_mask <= mask_data;
      irq <= |(irq_src & int_mask);
    end
  end

endmodule

// File: tb/tb_status_reg_irq.sv
module tb_status_reg_irq;
  import status_reg_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;

  // dut_t: all bits transparent, mask resets to 8'h0F
  logic [7:0] status_t, rd_data_t, mask_data_t, int_mask_t;
  logic       rd_req_t, rd_ack_t, mask_wr_t, irq_t;
  // dut_s: upper nibble sticky, mask resets to 0
  logic [7:0] status_s, rd_data_s, mask_data_s, int_mask_s;
  logic       rd_req_s, rd_ack_s, mask_wr_s, irq_s;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  status_reg_irq #(
    .WIDTH(8), .MODE_MASK(32'h0000_0000), .INT_MASK_INIT(32'h0000_000F)
  ) dut_t (
    .clock(clock), .reset_n(reset_n), .status(status_t),
    .rd_req(rd_req_t), .rd_ack(rd_ack_t), .rd_data(rd_data_t),
    .mask_wr(mask_wr_t), .mask_data(mask_data_t), .int_mask(int_mask_t), .irq(irq_t)
  );

  status_reg_irq #(
    .WIDTH(8), .MODE_MASK(32'h0000_00F0), .INT_MASK_INIT(32'h0000_0000)
  ) dut_s (
    .clock(clock), .reset_n(reset_n), .status(status_s),
    .rd_req(rd_req_s), .rd_ack(rd_ack_s), .rd_data(rd_data_s),
    .mask_wr(mask_wr_s), .mask_data(mask_data_s), .int_mask(int_mask_s), .irq(irq_s)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full read on dut_s; ok=1 only if ack is absent after 1 edge and present after 2.
  task automatic read_s(output logic [7:0] data, output logic ok);
    logic a1;
    rd_req_s = 1'b1;
    tick();
    a1 = rd_ack_s;
    tick();
    ok   = !a1 && rd_ack_s;
    data = rd_data_s;
    rd_req_s = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_t(output logic [7:0] data, output logic ok);
    logic a1;
    rd_req_t = 1'b1;
    tick();
    a1 = rd_ack_t;
    tick();
    ok   = !a1 && rd_ack_t;
    data = rd_data_t;
    rd_req_t = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_transparent();
    status_t = 8'hA5;
    rd_req_t = 1'b1;
    tick();
    n_total++;
    if (rd_ack_t !== 1'b0) $display("FAIL trans_ack_early: got %b want 0", rd_ack_t);
    else n_pass++;
    tick();
    n_total++;
    if (rd_ack_t !== 1'b1) $display("FAIL trans_ack: got %b want 1", rd_ack_t);
    else n_pass++;
    n_total++;
    if (rd_data_t !== 8'hA5) $display("FAIL trans_data: got %h want a5", rd_data_t);
    else n_pass++;
    rd_req_t = 1'b0;
    tick();
    n_total++;
    if (rd_ack_t !== 1'b0) $display("FAIL trans_ack_pulse: got %b want 0", rd_ack_t);
    else n_pass++;
    tick();
    // stat_q = A5, mask 0F -> irq level high
    n_total++;
    if (irq_t !== 1'b1) $display("FAIL trans_irq_high: got %b want 1", irq_t);
    else n_pass++;
    status_t = 8'h00;
    tick();
    n_total++;
    if (dut_t.stat_q !== 8'h00) $display("FAIL trans_stat_drop: got %h want 00", dut_t.stat_q);
    else n_pass++;
    n_total++;
    if (irq_t !== 1'b1) $display("FAIL trans_irq_latency: got %b want 1", irq_t);
    else n_pass++;
    tick();
    n_total++;
    if (irq_t !== 1'b0) $display("FAIL trans_irq_low: got %b want 0", irq_t);
    else n_pass++;
    n_total++;
    if (rd_data_t !== 8'hA5) $display("FAIL trans_data_hold: got %h want a5", rd_data_t);
    else n_pass++;
  endtask

  task automatic test_reset();
    int acks;
    status_t    = 8'h0F;
    mask_wr_t   = 1'b1;
    mask_data_t = 8'hFF;
    tick();
    mask_wr_t = 1'b0;
    tick();
    n_total++;
    if (irq_t !== 1'b1) $display("FAIL rst_pre_irq: got %b want 1", irq_t);
    else n_pass++;
    rd_req_t = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    n_total++;
    if (rd_data_t !== 8'h00) $display("FAIL rst_rd_data: got %h want 00", rd_data_t);
    else n_pass++;
    n_total++;
    if (irq_t !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq_t);
    else n_pass++;
    n_total++;
    if (int_mask_t !== 8'h0F) $display("FAIL rst_int_mask_t: got %h want 0f", int_mask_t);
    else n_pass++;
    n_total++;
    if (int_mask_s !== 8'h00) $display("FAIL rst_int_mask_s: got %h want 00", int_mask_s);
    else n_pass++;
    rd_req_t = 1'b0;
    status_t = 8'h00;
    tick();
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rd_ack_t === 1'b1) acks++;
    end
    n_total++;
    if (acks !== 0) $display("FAIL rst_no_ack: got %0d acks want 0", acks);
    else n_pass++;
  endtask

  task automatic test_sticky();
    logic [7:0] d;
    logic       ok;
    status_s = 8'h30;
    tick();
    status_s = 8'h00;
    tick();
    n_total++;
    if (dut_s.stat_q !== 8'h30) $display("FAIL sticky_hold: got %h want 30", dut_s.stat_q);
    else n_pass++;
    read_s(d, ok);
    n_total++;
    if (!ok || d !== 8'h30) $display("FAIL sticky_read1: got %h ack_ok %b want 30 ack_ok 1", d, ok);
    else n_pass++;
    read_s(d, ok);
    n_total++;
    if (!ok || d !== 8'h00) $display("FAIL sticky_read2: got %h ack_ok %b want 00 ack_ok 1", d, ok);
    else n_pass++;
  endtask

  task automatic test_set_wins();
    logic [7:0] d;
    logic       ok;
    rd_req_s = 1'b1;
    tick();
    // FSM now in CAPTURE: bit 7 rises exactly here
    status_s = 8'h80;
    tick();
    n_total++;
    if (rd_ack_s !== 1'b1 || rd_data_s !== 8'h00)
      $display("FAIL setwins_read1: got ack %b data %h want ack 1 data 00", rd_ack_s, rd_data_s);
    else n_pass++;
    status_s = 8'h00;
    rd_req_s = 1'b0;
    tick();
    tick();
    read_s(d, ok);
    n_total++;
    if (!ok || d !== 8'h80) $display("FAIL setwins_read2: got %h ack_ok %b want 80 ack_ok 1", d, ok);
    else n_pass++;
  endtask

  task automatic test_irq_mask();
    status_s = 8'h10;
    tick();
    status_s = 8'h00;
    tick();
    tick();
    n_total++;
    if (irq_s !== 1'b0) $display("FAIL irq_masked: got %b want 0", irq_s);
    else n_pass++;
    mask_wr_s   = 1'b1;
    mask_data_s = 8'h10;
    tick();
    mask_wr_s = 1'b0;
    n_total++;
    if (int_mask_s !== 8'h10 || irq_s !== 1'b0)
      $display("FAIL irq_mask_edge1: got mask %h irq %b want mask 10 irq 0", int_mask_s, irq_s);
    else n_pass++;
    tick();
    n_total++;
    if (irq_s !== 1'b1) $display("FAIL irq_mask_edge2: got %b want 1", irq_s);
    else n_pass++;
    rd_req_s = 1'b1;
    tick();
    tick();
    n_total++;
    if (rd_data_s !== 8'h10 || irq_s !== 1'b1)
      $display("FAIL irq_read: got data %h irq %b want data 10 irq 1", rd_data_s, irq_s);
    else n_pass++;
    tick();
    n_total++;
    if (irq_s !== 1'b0) $display("FAIL irq_cleared: got %b want 0", irq_s);
    else n_pass++;
    rd_req_s = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       ok;
    int         acks;
    status_t = 8'h3C;
    rd_req_t = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_ack_t === 1'b1) acks++;
    end
    n_total++;
    if (acks !== 1) $display("FAIL hold_one_ack: got %0d acks want 1", acks);
    else n_pass++;
    n_total++;
    if (rd_data_t !== 8'h3C) $display("FAIL hold_data: got %h want 3c", rd_data_t);
    else n_pass++;
    rd_req_t = 1'b0;
    tick();
    n_total++;
    if (dut_t.state !== IDLE) $display("FAIL hold_idle: got %0d want %0d", dut_t.state, IDLE);
    else n_pass++;
    status_t = 8'hC3;
    tick();
    read_t(d, ok);
    n_total++;
    if (!ok || d !== 8'hC3) $display("FAIL hold_new_read: got %h ack_ok %b want c3 ack_ok 1", d, ok);
    else n_pass++;
  endtask

  initial begin
    reset_n     = 1'b0;
    status_t    = '0; rd_req_t = 1'b0; mask_wr_t = 1'b0; mask_data_t = '0;
    status_s    = '0; rd_req_s = 1'b0; mask_wr_s = 1'b0; mask_data_s = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    test_transparent();
    test_reset();
    test_sticky();
    test_set_wins();
    test_irq_mask();
    test_back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/status_reg_irq.md
Name: status_reg_irq

Overview:
- Parametrised status register: samples WIDTH status nets on clock and holds them for a firmware read.
- Per-bit sticky or transparent mode; sticky bits clear on read.
- Adds a maskable interrupt output and a req/ack read handshake.
- Sits between datapath status nets and the bus-side register interface; successor to the fixed 8-bit status register primitive.

Parameters:
- WIDTH, 8, number of status bits (1..32).
- MODE_MASK, 0, WIDTH-bit vector; bit=1 makes that bit sticky (latch-high, clear-on-read), bit=0 makes it transparent.
- INT_MASK_INIT, 0, WIDTH-bit reset value of the interrupt mask register.

Ports:
- clock  input  1  block clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- status  input  WIDTH  status nets, synchronous to clock.
- rd_req  input  1  read request, level, held until rd_ack seen.
- rd_ack  output  1  one-cycle pulse: rd_data valid.
- rd_data  output  WIDTH  captured status value.
- mask_wr  input  1  write strobe for interrupt mask.
- mask_data  input  WIDTH  new interrupt mask value.
- int_mask  output  WIDTH  current interrupt mask.
- irq  output  1  registered OR of (stat_q & int_mask).

Behaviour:
- Reset (async, reset_n=0): stat_q=0, rd_data=0, rd_ack=0, irq=0, int_mask=INT_MASK_INIT, FSM=IDLE.
- Sampling each cycle, per bit i:
  - Transparent bit: stat_q[i] <= status[i].
  - Sticky bit: stat_q[i] <= status[i] | (stat_q[i] & ~clr[i]).
  - clr is asserted only in the capture cycle, and only on sticky bits.
  - Set wins over clear: a status high in the capture cycle leaves the bit 1 after the read.
- Latency: status -> stat_q 1 cycle; stat_q -> irq 1 cycle; status -> irq 2 cycles total.
- irq <= |(stat_q & int_mask).
- mask_wr: int_mask <= mask_data next edge; affects irq on the edge after that.
- Read FSM:
  - IDLE: rd_req=1 -> CAPTURE.
  - CAPTURE (1 cycle): rd_data <= stat_q, clr = MODE_MASK; -> ACK.
  - ACK (1 cycle): rd_ack=1; -> HOLD.
  - HOLD: wait until rd_req=0 -> IDLE.
  - Request still high in HOLD never produces a second capture.
  - rd_req -> rd_ack latency: 2 cycles.
- rd_data holds its last captured value until the next capture.
- Simultaneous events:
  - mask_wr during a read is independent of the FSM.
  - Status edges during CAPTURE are captured on the following cycle; they are not lost, because set wins.
- Reset mid-read: FSM returns to IDLE, no rd_ack issued, sticky state lost; the requester must re-issue.
- WIDTH=1 is legal. MODE_MASK bits above WIDTH are ignored.

Optional Feature:
- Macro: STATUS_REG_IRQ_EDGE_EN.
- Defined:
  - Sticky bits set on the rising edge of status: status[i] & ~status_d[i], using a 1-flop history register status_d (reset 0).
  - irq becomes a one-cycle pulse on any new masked sticky set, instead of a level.
  - Transparent bits are unchanged.
- Undefined: level-set sticky bits and level irq, as above.

Decomposition:
- Package status_reg_pkg:
  - FSM state enum: IDLE, CAPTURE, ACK, HOLD.
  - Localparam MAX_WIDTH=32.
  - Function building the sticky/clear vector from MODE_MASK and WIDTH.
- Sub-module status_reg_bit: one status bit (sticky/transparent select, set-wins-clear, optional edge detect); generated WIDTH times.
- FSM, mask register and irq logic live in the top.

Test Plan:
- Reset/defaults (WIDTH=8, INT_MASK_INIT=8'h0F): assert reset_n=0 mid-run -> rd_data=0, irq=0, int_mask=8'h0F immediately, without waiting for a clock edge.
- Transparent read (MODE_MASK=0):
  - Drive status=8'hA5, raise rd_req -> rd_ack pulse 2 cycles later, rd_data=8'hA5.
  - Drop status to 0 -> stat_q=0 next cycle.
- Sticky clear-on-read (MODE_MASK=8'hF0):
  - Pulse status=8'h30 for 1 cycle, then 0; read -> rd_data=8'h30.
  - Second read -> rd_data=8'h00.
- Set-wins-clear: sticky bit 7 pulsed high exactly in the CAPTURE cycle -> first read shows bit7=0, second read shows bit7=1.
- Interrupt mask:
  - int_mask=0, sticky bit4 set -> irq stays 0.
  - mask_wr with 8'h10 -> irq=1 two edges after the strobe.
  - Read clears bit4 -> irq=0 two cycles after CAPTURE.
- Handshake hold: rd_req held high 10 cycles -> exactly one rd_ack; dropping rd_req returns the FSM to IDLE; a new request gives a new capture.
